// File: rtl/lms_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lms_ctrl                                                   |
// | Description : FFE/LMS adaptation controller. Owns the FFE coefficient    |
// |               bank, sequences adaptation (fill, decimated commits,       |
// |               freeze) and gear-shifts the LMS step size.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// Ports:
//   i_clock      - clock
//   i_reset      - asynchronous active-low reset, synchronous release
//   i_valid      - sample strobe shared with FFE and adapter
//   i_enable     - level, 1 runs adaptation, 0 idles (coefficients held)
//   i_freeze     - level, suspends commits while adapting
//   i_clear      - sync pulse, coefficients/gear back to init, go idle
//   i_new_coeff  - adapter proposal, tap k at [k*NB +: NB]
//   o_coeff_flat - registered coefficient bank, same packing
//   o_mu         - current step size, MU_INIT >>> o_gear
//   o_update     - one-cycle pulse on each commit
//   o_state      - IDLE=0, FILL=1, ADAPT=2, FROZEN=3
//   o_gear       - current gear, 0..GEAR_MAX
// Coefficients are Q1.7 (NB=8, 7 fractional bits); the controller never
// does arithmetic on them, so the format only matters to the adapter.
module lms_ctrl #(
  parameter int               FFE_LEN     = 21,
  parameter int               NB          = 8,
  parameter int               NB_MU       = 16,
  parameter logic [NB-1:0]    INIT_CENTER = 8'h7F,
  parameter int               START_DLY   = 32,
  parameter int               UPD_PERIOD  = 4,
  parameter int               GEAR_LEN    = 1024,
  parameter logic [NB_MU-1:0] MU_INIT     = 16'h0400,
  parameter int               GEAR_MAX    = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic                      i_enable,
  input  logic                      i_freeze,
  input  logic                      i_clear,
  input  logic [FFE_LEN*NB-1:0]     i_new_coeff,
  output logic [FFE_LEN*NB-1:0]     o_coeff_flat,
  output logic signed [NB_MU-1:0]   o_mu,
  output logic                      o_update,
  output logic [1:0]                o_state,
  output logic [2:0]                o_gear
);

  localparam int FILL_W = (START_DLY > 1)  ? $clog2(START_DLY)  : 1;
  localparam int PER_W  = (UPD_PERIOD > 1) ? $clog2(UPD_PERIOD) : 1;
  localparam int GCNT_W = (GEAR_LEN > 1)   ? $clog2(GEAR_LEN)   : 1;

  localparam logic [FILL_W-1:0] c_FILL_LAST = FILL_W'(START_DLY - 1);
  localparam logic [PER_W-1:0]  c_PER_LAST  = PER_W'(UPD_PERIOD - 1);
  localparam logic [GCNT_W-1:0] c_GCNT_LAST = GCNT_W'(GEAR_LEN - 1);
  localparam logic [2:0]        c_GEAR_MAX  = 3'(GEAR_MAX);

  // Center tap (index FFE_LEN/2) at INIT_CENTER, all others zero.
  localparam logic [FFE_LEN*NB-1:0] c_INIT_COEFF =
    {{((FFE_LEN-1)*NB){1'b0}}, INIT_CENTER} << ((FFE_LEN/2)*NB);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_ADAPT  = 2'd2,
    ST_FROZEN = 2'd3
  } state_t;

  state_t                    r_state;
  logic [FFE_LEN*NB-1:0]     r_coeff;
  logic signed [NB_MU-1:0]   r_mu;
  logic                      r_update;
  logic [2:0]                r_gear;
  logic [FILL_W-1:0]         r_fill_cnt;
  logic [PER_W-1:0]          r_per_cnt;
  logic [GCNT_W-1:0]         r_gcnt;

  logic [2:0]                w_gear_inc;

  assign w_gear_inc = r_gear + 3'd1;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_coeff    <= c_INIT_COEFF;
      r_mu       <= MU_INIT;
      r_update   <= 1'b0;
      r_gear     <= 3'd0;
      r_fill_cnt <= '0;
      r_per_cnt  <= '0;
      r_gcnt     <= '0;
    end else begin
      r_update <= 1'b0;
      if (i_clear) begin
        // Clear beats everything, including a commit in the same cycle.
        r_state    <= ST_IDLE;
        r_coeff    <= c_INIT_COEFF;
        r_mu       <= MU_INIT;
        r_gear     <= 3'd0;
        r_fill_cnt <= '0;
        r_per_cnt  <= '0;
        r_gcnt     <= '0;
      end else if (!i_enable) begin
        // Coefficients and gear survive a disable; only sequencing restarts.
        r_state    <= ST_IDLE;
        r_fill_cnt <= '0;
        r_per_cnt  <= '0;
        r_gcnt     <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_FILL;
            r_fill_cnt <= '0;
          end
          ST_FILL: begin
            if (START_DLY == 0) begin
              r_state   <= ST_ADAPT;
              r_per_cnt <= '0;
            end else if (i_valid) begin
              if (r_fill_cnt == c_FILL_LAST) begin
                r_state    <= ST_ADAPT;
                r_per_cnt  <= '0;
                r_fill_cnt <= '0;
              end else begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
              end
            end
          end
          ST_ADAPT: begin
            // Freeze acts in the cycle it is seen: it pre-empts a commit.
            if (i_freeze) begin
              r_state <= ST_FROZEN;
            end else if (i_valid) begin
              if (r_per_cnt == c_PER_LAST) begin
                r_coeff   <= i_new_coeff;
                r_update  <= 1'b1;
                r_per_cnt <= '0;
                if (r_gcnt == c_GCNT_LAST) begin
                  r_gcnt <= '0;
                  // mu moves on the same edge as the gear it belongs to.
                  if (r_gear < c_GEAR_MAX) begin
                    r_gear <= w_gear_inc;
                    r_mu   <= $signed(MU_INIT) >>> w_gear_inc;
                  end
                end else begin
                  r_gcnt <= r_gcnt + 1'b1;
                end
              end else begin
                r_per_cnt <= r_per_cnt + 1'b1;
              end
            end
          end
          ST_FROZEN: begin
            if (!i_freeze) begin
              r_state   <= ST_ADAPT;
              r_per_cnt <= '0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_coeff_flat = r_coeff;
  assign o_mu         = r_mu;
  assign o_update     = r_update;
  assign o_state      = r_state;
  assign o_gear       = r_gear;

endmodule
`default_nettype wire

// File: tb/tb_lms_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lms_ctrl                                                |
// | Description : Self-checking bench for lms_ctrl. Expected commits (coeff, |
// |               gear, mu) are queued when stimulus is driven and popped by |
// |               a monitor whenever the DUT pulses o_update.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_lms_ctrl;
  localparam int FFE_LEN  = 21;
  localparam int NB       = 8;
  localparam int W        = FFE_LEN * NB;
  localparam int GEAR_LEN = 3;
  localparam int GEAR_MAX = 2;

  logic         clk = 1'b0;
  logic         rst_n, valid, enable, freeze, clear;
  logic [W-1:0] new_coeff;
  logic [W-1:0] coeff;
  logic signed [15:0] mu;
  logic         upd;
  logic [1:0]   st;
  logic [2:0]   gear;

  always #5 clk = ~clk;

  lms_ctrl #(
    .FFE_LEN(FFE_LEN), .NB(NB), .NB_MU(16), .INIT_CENTER(8'h7F),
    .START_DLY(4), .UPD_PERIOD(2), .GEAR_LEN(GEAR_LEN),
    .MU_INIT(16'h0400), .GEAR_MAX(GEAR_MAX)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_enable(enable),
    .i_freeze(freeze), .i_clear(clear), .i_new_coeff(new_coeff),
    .o_coeff_flat(coeff), .o_mu(mu), .o_update(upd), .o_state(st),
    .o_gear(gear)
  );

  typedef struct packed {
    logic [W-1:0] c;
    logic [2:0]   g;
    logic [15:0]  m;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           total = 0;
  int           bad = 0;
  int           n_commit = 0;
  logic [W-1:0] init_c;
  logic [W-1:0] last_c;

  function automatic logic [W-1:0] fill(input logic [7:0] b);
    logic [W-1:0] v;
    for (int k = 0; k < FFE_LEN; k++) v[k*NB +: NB] = b;
    return v;
  endfunction

  function automatic logic [W-1:0] pat(input int n);
    logic [W-1:0] v;
    for (int k = 0; k < FFE_LEN; k++) v[k*NB +: NB] = 8'(n * 16 + k);
    return v;
  endfunction

  function automatic logic [2:0] exp_gear(input int n);
    int g;
    g = n / GEAR_LEN;
    if (g > GEAR_MAX) g = GEAR_MAX;
    return 3'(g);
  endfunction

  function automatic logic [15:0] exp_mu(input logic [2:0] g);
    return 16'h0400 >> g;
  endfunction

  // Record the commit the DUT should produce for the stimulus now driven.
  task automatic push_commit(input logic [W-1:0] c);
    exp_t e;
    n_commit++;
    e.c = c;
    e.g = exp_gear(n_commit);
    e.m = exp_mu(e.g);
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every update pulse must match the oldest expectation.
  always begin
    @(posedge clk); #1;
    if (upd === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_update: got update=1 coeff=%h, required no commit", coeff);
      end else begin
        mon_e = exp_q.pop_front();
        if (coeff !== mon_e.c || gear !== mon_e.g || mu !== mon_e.m) begin
          bad++;
          $display("FAIL sb_commit: got coeff=%h gear=%0d mu=%h, required coeff=%h gear=%0d mu=%h",
                   coeff, gear, mu, mon_e.c, mon_e.g, mon_e.m);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; enable = 1'b0; freeze = 1'b0; clear = 1'b0;
    new_coeff = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (coeff !== init_c) begin bad++; $display("FAIL reset_coeff: got %h required %h", coeff, init_c); end
    total++; if (mu !== 16'sh0400) begin bad++; $display("FAIL reset_mu: got %h required 0400", mu); end
    total++; if (st !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d required 0", st); end
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL reset_update: got %b required 0", upd); end
    total++; if (gear !== 3'd0) begin bad++; $display("FAIL reset_gear: got %0d required 0", gear); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (st !== 2'd0) begin bad++; $display("FAIL idle_hold: got state %0d required 0", st); end
  endtask

  task automatic test_fill_first_commit();
    enable = 1'b1; valid = 1'b1; new_coeff = fill(8'h11);
    push_commit(fill(8'h11));
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      total++;
      if (st !== ((c <= 4) ? 2'd1 : 2'd2)) begin
        bad++; $display("FAIL fill_state cycle %0d: got %0d required %0d", c, st, (c <= 4) ? 1 : 2);
      end
      total++;
      if (upd !== (c == 7)) begin
        bad++; $display("FAIL fill_update cycle %0d: got %b required %b", c, upd, (c == 7));
      end
    end
  endtask

  task automatic test_gear_shift();
    for (int n = 2; n <= 12; n++) begin
      new_coeff = pat(n);
      push_commit(pat(n));
      for (int c = 1; c <= 2; c++) begin
        @(posedge clk); #1;
        total++;
        if (upd !== (c == 2)) begin
          bad++; $display("FAIL period_update commit %0d step %0d: got %b required %b", n, c, upd, (c == 2));
        end
      end
      if (n % 3 == 0) begin
        total++;
        if (gear !== exp_gear(n) || mu !== exp_mu(exp_gear(n))) begin
          bad++; $display("FAIL gear_after_commit %0d: got gear=%0d mu=%h required gear=%0d mu=%h",
                          n, gear, mu, exp_gear(n), exp_mu(exp_gear(n)));
        end
      end
    end
    last_c = pat(12);
  endtask

  task automatic test_freeze();
    // One valid sample so the freeze lands on a commit-ready cycle.
    @(posedge clk); #1;
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL pre_freeze_update: got %b required 0", upd); end
    freeze = 1'b1; new_coeff = fill(8'hEE);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      total++;
      if (st !== 2'd3 || upd !== 1'b0 || coeff !== last_c) begin
        bad++; $display("FAIL frozen cycle %0d: got state=%0d update=%b coeff=%h required state=3 update=0 coeff=%h",
                        c, st, upd, coeff, last_c);
      end
    end
    freeze = 1'b0;
    push_commit(fill(8'hEE));
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      total++;
      if (st !== 2'd2 || upd !== (c == 3)) begin
        bad++; $display("FAIL unfreeze cycle %0d: got state=%0d update=%b required state=2 update=%b",
                        c, st, upd, (c == 3));
      end
    end
    total++; if (gear !== 3'd2) begin bad++; $display("FAIL freeze_gear_kept: got %0d required 2", gear); end
  endtask

  task automatic test_valid_gaps();
    logic vseq [4];
    vseq = '{1'b1, 1'b0, 1'b0, 1'b1};
    new_coeff = fill(8'h5A);
    push_commit(fill(8'h5A));
    for (int i = 0; i < 4; i++) begin
      valid = vseq[i];
      @(posedge clk); #1;
      total++;
      if (upd !== (i == 3)) begin
        bad++; $display("FAIL valid_gap step %0d: got update=%b required %b", i, upd, (i == 3));
      end
    end
    valid = 1'b1;
  endtask

  task automatic test_clear();
    new_coeff = fill(8'h33);
    @(posedge clk); #1;
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL pre_clear_update: got %b required 0", upd); end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_commit = 0;
    total++;
    if (upd !== 1'b0 || coeff !== init_c || gear !== 3'd0 || mu !== 16'sh0400 || st !== 2'd0) begin
      bad++; $display("FAIL clear: got update=%b coeff=%h gear=%0d mu=%h state=%0d required update=0 coeff=%h gear=0 mu=0400 state=0",
                      upd, coeff, gear, mu, st, init_c);
    end
    @(posedge clk); #1;
    total++; if (st !== 2'd1) begin bad++; $display("FAIL clear_then_fill: got state %0d required 1", st); end
  endtask

  task automatic test_enable_drop();
    // Finish the fill (4 valid samples), then reach a commit-ready cycle.
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (st !== ((c <= 3) ? 2'd1 : 2'd2) || upd !== 1'b0) begin
        bad++; $display("FAIL refill cycle %0d: got state=%0d update=%b required state=%0d update=0",
                        c, st, upd, (c <= 3) ? 1 : 2);
      end
    end
    enable = 1'b0;
    @(posedge clk); #1;
    total++;
    if (upd !== 1'b0 || st !== 2'd0 || coeff !== init_c) begin
      bad++; $display("FAIL enable_drop: got update=%b state=%0d coeff=%h required update=0 state=0 coeff=%h",
                      upd, st, coeff, init_c);
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b1; new_coeff = fill(8'h77);
    push_commit(fill(8'h77));
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      total++;
      if (upd !== (c == 7)) begin
        bad++; $display("FAIL rerun_update cycle %0d: got %b required %b", c, upd, (c == 7));
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (coeff !== init_c || upd !== 1'b0 || st !== 2'd0 || gear !== 3'd0 || mu !== 16'sh0400) begin
      bad++; $display("FAIL async_reset: got coeff=%h update=%b state=%0d gear=%0d mu=%h required init values",
                      coeff, upd, st, gear, mu);
    end
    enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (st !== 2'd0) begin bad++; $display("FAIL post_reset_idle: got state %0d required 0", st); end
  endtask

  initial begin
    init_c = '0;
    init_c[10*NB +: NB] = 8'h7F;
    test_reset();
    test_fill_first_commit();
    test_gear_shift();
    test_freeze();
    test_valid_gaps();
    test_clear();
    test_enable_drop();
    test_async_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_pending: got %0d commits outstanding required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire
